rf_write_arbiter: RTL and testbench
===================================

RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 Parameter DEPTH, default 2, entries per requester buffer; SHALL be a power of two and at least 2.
REQ-002 CLK  input  1  clock; all state updates on posedge.
REQ-003 nRST  input  1  reset, asynchronous, active-low.
REQ-004 alu_valid / alu_ready  input / output  1 each  ALU writeback handshake (requester 0).
REQ-005 alu_wsel / alu_wdat  input  regbits_t / word_t  ALU destination register and data.
REQ-006 mem_valid / mem_ready  input / output  1 each  load writeback handshake (requester 1).
REQ-007 mem_wsel / mem_wdat  input  regbits_t / word_t  load destination register and data.
REQ-008 rf_WEN / rf_wsel / rf_wdat  output  1 / regbits_t / word_t  register file write port.
REQ-009 rsel1 / rsel2  input  regbits_t  read selects being decoded this cycle.
REQ-010 busy1 / busy2  output  1  a pending buffered write targets rsel1 / rsel2.
REQ-011 fwd1_valid, fwd1_dat / fwd2_valid, fwd2_dat  output  1, word_t  forwarded pending data.

Function
REQ-012 A transfer occurs on a posedge where valid and ready are both high; ready SHALL equal "buffer not full", with no dependence on valid or same-cycle pop.
REQ-013 A transfer with wsel == 0 SHALL be accepted and discarded, never stored or written.
REQ-014 Each requester buffer SHALL be FIFO; order within one requester SHALL be preserved.
REQ-015 rf_WEN SHALL be high whenever either buffer is non-empty; rf_wsel/rf_wdat SHALL be the granted head entry, else zero.
REQ-016 Grant: only one buffer non-empty -> that buffer; both non-empty -> the requester not granted last (round-robin).
REQ-017 The granted head SHALL be popped on the same posedge the register file captures it; latency from accept to write SHALL be at least one cycle.
REQ-018 Simultaneous push and pop on one buffer SHALL be legal; occupancy is then unchanged.
REQ-019 Simultaneous push and pop on a full buffer SHALL NOT occur, because ready is low.
REQ-020 busyN SHALL be high iff rselN != 0 and it matches wsel of any stored entry in either buffer; incoming unaccepted data SHALL NOT count.
REQ-021 Cross-requester WAW ordering is not guaranteed; the pipeline SHALL stall on busy.

Reset
REQ-022 On nRST low, both buffers SHALL empty and the round-robin state SHALL give requester 0 priority next.
REQ-023 During reset, ready, rf_WEN, busy and fwd outputs SHALL be 0 and rf_wsel/rf_wdat SHALL be 0.
REQ-024 Reset mid-operation SHALL discard all pending entries without writing them.

Configuration
REQ-025 Macro RF_ARB_FWD_EN defined: fwdN_valid SHALL be high iff exactly one buffer holds entries matching rselN.
REQ-026 With RF_ARB_FWD_EN defined, fwdN_dat SHALL be the youngest matching entry's data.
REQ-027 With RF_ARB_FWD_EN defined, if both buffers match, fwdN_valid SHALL be 0 and busyN SHALL stay 1.
REQ-028 Macro undefined: fwdN_valid and fwdN_dat SHALL be tied 0; ports SHALL remain present.

Structure
REQ-029 cpu_types_pkg SHALL gain rf_arb_entry_t (regbits_t wsel, word_t wdat) and constant RF_ARB_DEPTH = 2.
REQ-030 Each buffer SHALL be one instance of sub-module rf_wb_fifo (DEPTH, push/pop/full/empty, entry vector visible for matching).
REQ-031 Expected size: 150-300 lines total.

Verification
REQ-032 ALU-only: one alu transfer (wsel 5, wdat 0xDEADBEEF) -> next cycle rf_WEN=1, wsel 5, data 0xDEADBEEF; then idle.
REQ-033 Contention: both valid every cycle, distinct wsel -> writes alternate ALU, MEM, ALU, ...; first grant after reset = ALU.
REQ-034 Backpressure: mem_valid held 4 cycles with arbiter blocked by ALU traffic -> mem_ready drops after 2 accepts; no loss; FIFO order kept.
REQ-035 Zero register: alu transfer wsel 0 -> accepted, rf_WEN stays 0, busy never set.
REQ-036 Hazard: mem buffer holds wsel 7 = 0x1234, rsel1=7 -> busy1=1; with RF_ARB_FWD_EN, fwd1_valid=1 and fwd1_dat=0x1234.
REQ-037 Reset mid-op: assert nRST low with 3 entries pending -> outputs 0 immediately; no writes occur after release.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU types plus the register-file write arbiter's
// buffer entry and default buffer depth.
//   regbits_t      register select (5 bits, register 0 is the hard zero)
//   word_t         data word (32 bits)
//   rf_arb_entry_t one buffered writeback: destination select and data
//   rr_state_e     round-robin priority state of the arbiter
package cpu_types_pkg;

  localparam int REG_W  = 5;
  localparam int WORD_W = 32;

  typedef logic [REG_W-1:0]  regbits_t;
  typedef logic [WORD_W-1:0] word_t;

  typedef struct packed {
    regbits_t wsel;
    word_t    wdat;
  } rf_arb_entry_t;

  localparam int RF_ARB_DEPTH = 2;

  typedef enum logic {
    RR_ALU = 1'b0,
    RR_MEM = 1'b1
  } rr_state_e;

endpackage

// File: rtl/rf_wb_fifo.sv
// rf_wb_fifo: writeback buffer for one requester of the register-file write
// arbiter. Circular FIFO of rf_arb_entry_t, DEPTH a power of two (>= 2).
// Ports:
//   CLK, nRST         clock, asynchronous active-low reset (empties buffer)
//   push_i, din_i     write an entry (ignored when full)
//   pop_i             drop the head entry (ignored when empty)
//   full_o, empty_o   occupancy flags
//   head_o            oldest entry
//   ent_o, ent_vld_o  all slots in age order (index 0 = oldest) with
//                     per-slot valid, used for hazard matching
module rf_wb_fifo
  import cpu_types_pkg::*;
#(
  parameter int DEPTH = RF_ARB_DEPTH
) (
  input  logic                      CLK,
  input  logic                      nRST,
  input  logic                      push_i,
  input  logic                      pop_i,
  input  rf_arb_entry_t             din_i,
  output logic                      full_o,
  output logic                      empty_o,
  output rf_arb_entry_t             head_o,
  output rf_arb_entry_t [DEPTH-1:0] ent_o,
  output logic [DEPTH-1:0]          ent_vld_o
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [PTR_W:0]   cnt_t;

  rf_arb_entry_t mem_q [DEPTH];
  ptr_t          rd_ptr_q, rd_ptr_d;
  ptr_t          wr_ptr_q, wr_ptr_d;
  cnt_t          cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == cnt_t'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + ptr_t'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + ptr_t'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + cnt_t'(1);
      2'b01:   cnt_d = cnt_q - cnt_t'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      if (do_push) mem_q[wr_ptr_q] <= din_i;
    end
  end

  // Age-ordered view: slot i is the i-th oldest stored entry.
  always_comb begin
    ent_o     = '0;
    ent_vld_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ent_o[i]     = mem_q[rd_ptr_q + ptr_t'(i)];
      ent_vld_o[i] = (cnt_t'(i) < cnt_q);
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: merges ALU and load writebacks onto the single register
// file write port. Each requester has its own rf_wb_fifo; the heads are
// arbitrated round-robin and the granted head is written and popped on the
// same edge. Pending entries are matched against the decode read selects to
// raise busy (stall) and, optionally, forward data.
// Optional feature: define RF_ARB_FWD_EN to enable forwarding of pending data
// on fwd1/fwd2; without it the fwd outputs are tied to zero.
// Ports:
//   CLK, nRST                         clock, async active-low reset
//   alu_valid/ready/wsel/wdat         requester 0 handshake and payload
//   mem_valid/ready/wsel/wdat         requester 1 handshake and payload
//   rf_WEN/rf_wsel/rf_wdat            register file write port
//   rsel1/rsel2                       read selects being decoded
//   busy1/busy2                       a buffered write targets rselN
//   fwd1_valid/dat, fwd2_valid/dat    forwarded pending data
// DEPTH must be a power of two and at least 2.
//
// Round-robin state (rr_q):
//   state  | meaning
//   RR_ALU | ALU wins if both buffers hold entries (reset value)
//   RR_MEM | MEM wins if both buffers hold entries
module rf_write_arbiter
  import cpu_types_pkg::*;
#(
  parameter int DEPTH = RF_ARB_DEPTH
) (
  input  logic     CLK,
  input  logic     nRST,
  input  logic     alu_valid,
  output logic     alu_ready,
  input  regbits_t alu_wsel,
  input  word_t    alu_wdat,
  input  logic     mem_valid,
  output logic     mem_ready,
  input  regbits_t mem_wsel,
  input  word_t    mem_wdat,
  output logic     rf_WEN,
  output regbits_t rf_wsel,
  output word_t    rf_wdat,
  input  regbits_t rsel1,
  input  regbits_t rsel2,
  output logic     busy1,
  output logic     busy2,
  output logic     fwd1_valid,
  output word_t    fwd1_dat,
  output logic     fwd2_valid,
  output word_t    fwd2_dat
);

  rf_arb_entry_t             alu_din, mem_din;
  rf_arb_entry_t             alu_head, mem_head;
  rf_arb_entry_t [DEPTH-1:0] alu_ent, mem_ent;
  logic [DEPTH-1:0]          alu_vld, mem_vld;
  logic                      alu_full, alu_empty, mem_full, mem_empty;
  logic                      alu_push, mem_push;
  logic                      gnt_alu, gnt_mem;
  rr_state_e                 rr_q, rr_d;
  logic [DEPTH-1:0]          alu_hit1, alu_hit2, mem_hit1, mem_hit2;

  // nRST gates ready so the handshake is closed while reset is held.
  assign alu_ready = nRST & ~alu_full;
  assign mem_ready = nRST & ~mem_full;

  // Writes to register 0 complete the handshake but are never buffered.
  assign alu_push = alu_valid & alu_ready & (alu_wsel != '0);
  assign mem_push = mem_valid & mem_ready & (mem_wsel != '0);

  assign alu_din = '{wsel: alu_wsel, wdat: alu_wdat};
  assign mem_din = '{wsel: mem_wsel, wdat: mem_wdat};

  rf_wb_fifo #(.DEPTH(DEPTH)) u_alu_fifo (
    .CLK       (CLK),
    .nRST      (nRST),
    .push_i    (alu_push),
    .pop_i     (gnt_alu),
    .din_i     (alu_din),
    .full_o    (alu_full),
    .empty_o   (alu_empty),
    .head_o    (alu_head),
    .ent_o     (alu_ent),
    .ent_vld_o (alu_vld)
  );

  rf_wb_fifo #(.DEPTH(DEPTH)) u_mem_fifo (
    .CLK       (CLK),
    .nRST      (nRST),
    .push_i    (mem_push),
    .pop_i     (gnt_mem),
    .din_i     (mem_din),
    .full_o    (mem_full),
    .empty_o   (mem_empty),
    .head_o    (mem_head),
    .ent_o     (mem_ent),
    .ent_vld_o (mem_vld)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) rr_q <= RR_ALU;
    else       rr_q <= rr_d;
  end

  // Any grant hands priority to the other requester for the next tie.
  always_comb begin
    gnt_alu = 1'b0;
    gnt_mem = 1'b0;
    rr_d    = rr_q;
    if (!alu_empty && !mem_empty) begin
      if (rr_q == RR_ALU) gnt_alu = 1'b1;
      else                gnt_mem = 1'b1;
    end else if (!alu_empty) begin
      gnt_alu = 1'b1;
    end else if (!mem_empty) begin
      gnt_mem = 1'b1;
    end
    if (gnt_alu) rr_d = RR_MEM;
    if (gnt_mem) rr_d = RR_ALU;
  end

  always_comb begin
    rf_WEN  = gnt_alu | gnt_mem;
    rf_wsel = '0;
    rf_wdat = '0;
    if (gnt_alu) begin
      rf_wsel = alu_head.wsel;
      rf_wdat = alu_head.wdat;
    end else if (gnt_mem) begin
      rf_wsel = mem_head.wsel;
      rf_wdat = mem_head.wdat;
    end
  end

  function automatic logic [DEPTH-1:0] match_vec(
    input rf_arb_entry_t [DEPTH-1:0] ent,
    input logic [DEPTH-1:0]          vld,
    input regbits_t                  rsel
  );
    logic [DEPTH-1:0] h;
    h = '0;
    for (int i = 0; i < DEPTH; i++)
      h[i] = vld[i] && (ent[i].wsel == rsel) && (rsel != '0);
    return h;
  endfunction

  assign alu_hit1 = match_vec(alu_ent, alu_vld, rsel1);
  assign alu_hit2 = match_vec(alu_ent, alu_vld, rsel2);
  assign mem_hit1 = match_vec(mem_ent, mem_vld, rsel1);
  assign mem_hit2 = match_vec(mem_ent, mem_vld, rsel2);

  assign busy1 = (|alu_hit1) | (|mem_hit1);
  assign busy2 = (|alu_hit2) | (|mem_hit2);

`ifdef RF_ARB_FWD_EN
  // Slots are age ordered, so the last hit in the scan is the youngest.
  function automatic word_t youngest(
    input rf_arb_entry_t [DEPTH-1:0] ent,
    input logic [DEPTH-1:0]          hit
  );
    word_t d;
    d = '0;
    for (int i = 0; i < DEPTH; i++)
      if (hit[i]) d = ent[i].wdat;
    return d;
  endfunction

  // When both buffers match, cross-requester order is unknown: no forward,
  // the stall on busy resolves it.
  assign fwd1_valid = (|alu_hit1) ^ (|mem_hit1);
  assign fwd2_valid = (|alu_hit2) ^ (|mem_hit2);
  assign fwd1_dat   = !fwd1_valid ? '0 :
                      (|alu_hit1) ? youngest(alu_ent, alu_hit1) :
                                    youngest(mem_ent, mem_hit1);
  assign fwd2_dat   = !fwd2_valid ? '0 :
                      (|alu_hit2) ? youngest(alu_ent, alu_hit2) :
                                    youngest(mem_ent, mem_hit2);
`else
  assign fwd1_valid = 1'b0;
  assign fwd2_valid = 1'b0;
  assign fwd1_dat   = '0;
  assign fwd2_dat   = '0;
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
module tb_rf_write_arbiter;
  import cpu_types_pkg::*;

`ifdef RF_ARB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic     CLK = 1'b0;
  logic     nRST = 1'b0;
  logic     alu_valid, mem_valid;
  logic     alu_ready, mem_ready;
  regbits_t alu_wsel, mem_wsel, rf_wsel, rsel1, rsel2;
  word_t    alu_wdat, mem_wdat, rf_wdat, fwd1_dat, fwd2_dat;
  logic     rf_WEN, busy1, busy2, fwd1_valid, fwd2_valid;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  rf_write_arbiter #(.DEPTH(2)) dut (
    .CLK(CLK), .nRST(nRST),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_wsel(alu_wsel), .alu_wdat(alu_wdat),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_wsel(mem_wsel), .mem_wdat(mem_wdat),
    .rf_WEN(rf_WEN), .rf_wsel(rf_wsel), .rf_wdat(rf_wdat),
    .rsel1(rsel1), .rsel2(rsel2), .busy1(busy1), .busy2(busy2),
    .fwd1_valid(fwd1_valid), .fwd1_dat(fwd1_dat),
    .fwd2_valid(fwd2_valid), .fwd2_dat(fwd2_dat)
  );

  typedef struct {
    logic av; regbits_t asel; word_t adat;
    logic mv; regbits_t msel; word_t mdat;
    regbits_t r1, r2;
    logic e_ardy, e_mrdy, e_wen; regbits_t e_wsel; word_t e_wdat;
    logic e_b1, e_b2;
  } vec_t;

  typedef struct { regbits_t sel; word_t dat; } wr_t;

  vec_t tbl [9];
  wr_t  exp_alu_q [$];
  wr_t  exp_mem_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Every write must be the oldest outstanding accepted transfer of one requester.
  always @(negedge CLK) begin
    if (nRST && rf_WEN) begin
      checks++;
      if (exp_alu_q.size() > 0 && exp_alu_q[0].sel == rf_wsel && exp_alu_q[0].dat == rf_wdat)
        void'(exp_alu_q.pop_front());
      else if (exp_mem_q.size() > 0 && exp_mem_q[0].sel == rf_wsel && exp_mem_q[0].dat == rf_wdat)
        void'(exp_mem_q.pop_front());
      else begin
        errors++;
        $display("FAIL write_order: got sel=%0d dat=%h, expected alu head (%0d pending) or mem head (%0d pending)",
                 rf_wsel, rf_wdat, exp_alu_q.size(), exp_mem_q.size());
      end
    end
  end

  task automatic drive(input logic av, input regbits_t asel, input word_t adat,
                       input logic mv, input regbits_t msel, input word_t mdat);
    alu_valid = av; alu_wsel = asel; alu_wdat = adat;
    mem_valid = mv; mem_wsel = msel; mem_wdat = mdat;
  endtask

  // Called after the negedge checks: records accepted transfers at the posedge.
  task automatic finish_cycle();
    logic a_acc, m_acc;
    wr_t  a_e, m_e;
    a_acc = alu_valid && alu_ready && (alu_wsel != '0);
    m_acc = mem_valid && mem_ready && (mem_wsel != '0);
    a_e = '{alu_wsel, alu_wdat};
    m_e = '{mem_wsel, mem_wdat};
    @(posedge CLK);
    if (a_acc) exp_alu_q.push_back(a_e);
    if (m_acc) exp_mem_q.push_back(m_e);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge CLK);
      finish_cycle();
    end
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    rsel1 = '0; rsel2 = '0;
    exp_alu_q.delete(); exp_mem_q.delete();
    repeat (2) @(posedge CLK);
    @(negedge CLK) nRST = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_queues_empty(input string tag);
    chk({tag, " alu_pending"}, exp_alu_q.size(), 0);
    chk({tag, " mem_pending"}, exp_mem_q.size(), 0);
  endtask

  initial begin
    // Contention + backpressure: writes alternate ALU/MEM, mem_ready drops after 2 accepts.
    tbl[0] = '{1, 1, 32'hA000_0001, 1, 17, 32'hB000_0001, 1, 17, 1, 1, 0, 0,  32'h0,          0, 0};
    tbl[1] = '{1, 2, 32'hA000_0002, 1, 18, 32'hB000_0002, 1, 17, 1, 1, 1, 1,  32'hA000_0001, 1, 1};
    tbl[2] = '{1, 3, 32'hA000_0003, 1, 19, 32'hB000_0003, 2, 18, 1, 0, 1, 17, 32'hB000_0001, 1, 1};
    tbl[3] = '{1, 4, 32'hA000_0004, 1, 19, 32'hB000_0003, 17, 3, 0, 1, 1, 2,  32'hA000_0002, 0, 1};
    tbl[4] = '{1, 4, 32'hA000_0004, 0, 0,  32'h0,         19, 0, 1, 0, 1, 18, 32'hB000_0002, 1, 0};
    tbl[5] = '{0, 0, 32'h0,         0, 0,  32'h0,         4, 19, 0, 1, 1, 3,  32'hA000_0003, 1, 1};
    tbl[6] = '{0, 0, 32'h0,         0, 0,  32'h0,         3, 4,  1, 1, 1, 19, 32'hB000_0003, 0, 1};
    tbl[7] = '{0, 0, 32'h0,         0, 0,  32'h0,         4, 19, 1, 1, 1, 4,  32'hA000_0004, 1, 0};
    tbl[8] = '{0, 0, 32'h0,         0, 0,  32'h0,         4, 0,  1, 1, 0, 0,  32'h0,          0, 0};

    // Outputs held at zero while reset is asserted, even with valid inputs.
    nRST = 1'b0;
    drive(1, 3, 32'h1111, 1, 4, 32'h2222);
    rsel1 = 3; rsel2 = 4;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst alu_ready", alu_ready, 0);
    chk("rst mem_ready", mem_ready, 0);
    chk("rst rf_WEN", rf_WEN, 0);
    chk("rst rf_wsel", rf_wsel, 0);
    chk("rst rf_wdat", rf_wdat, 0);
    chk("rst busy1", busy1, 0);
    chk("rst fwd1_valid", fwd1_valid, 0);
    do_reset();

    // ALU-only single write.
    drive(1, 5, 32'hDEAD_BEEF, 0, 0, 0);
    @(negedge CLK);
    chk("alu1 alu_ready", alu_ready, 1);
    chk("alu1 no same-cycle write", rf_WEN, 0);
    finish_cycle();
    drive(0, 0, 0, 0, 0, 0);
    rsel1 = 5;
    @(negedge CLK);
    chk("alu1 rf_WEN", rf_WEN, 1);
    chk("alu1 rf_wsel", rf_wsel, 5);
    chk("alu1 rf_wdat", rf_wdat, 32'hDEAD_BEEF);
    chk("alu1 busy1", busy1, 1);
    finish_cycle();
    @(negedge CLK);
    chk("alu1 idle rf_WEN", rf_WEN, 0);
    chk("alu1 idle busy1", busy1, 0);
    finish_cycle();

    // Write to register 0 is accepted and dropped.
    drive(1, 0, 32'h55, 0, 0, 0);
    rsel1 = 0;
    @(negedge CLK);
    chk("zero alu_ready", alu_ready, 1);
    finish_cycle();
    drive(0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      chk($sformatf("zero c%0d rf_WEN", k), rf_WEN, 0);
      chk($sformatf("zero c%0d busy1", k), busy1, 0);
      finish_cycle();
    end
    chk_queues_empty("zero");

    // Table-driven contention / backpressure sequence.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].av, tbl[i].asel, tbl[i].adat, tbl[i].mv, tbl[i].msel, tbl[i].mdat);
      rsel1 = tbl[i].r1; rsel2 = tbl[i].r2;
      @(negedge CLK);
      chk($sformatf("row%0d alu_ready", i), alu_ready, tbl[i].e_ardy);
      chk($sformatf("row%0d mem_ready", i), mem_ready, tbl[i].e_mrdy);
      chk($sformatf("row%0d rf_WEN", i), rf_WEN, tbl[i].e_wen);
      chk($sformatf("row%0d rf_wsel", i), rf_wsel, tbl[i].e_wsel);
      chk($sformatf("row%0d rf_wdat", i), rf_wdat, tbl[i].e_wdat);
      chk($sformatf("row%0d busy1", i), busy1, tbl[i].e_b1);
      chk($sformatf("row%0d busy2", i), busy2, tbl[i].e_b2);
      finish_cycle();
    end
    chk_queues_empty("table");

    // Hazard on a pending load write.
    do_reset();
    drive(0, 0, 0, 1, 7, 32'h1234);
    @(negedge CLK);
    finish_cycle();
    drive(0, 0, 0, 0, 0, 0);
    rsel1 = 7;
    @(negedge CLK);
    chk("haz busy1", busy1, 1);
    chk("haz fwd1_valid", fwd1_valid, FWD);
    chk("haz fwd1_dat", fwd1_dat, FWD ? 32'h1234 : 32'h0);
    finish_cycle();
    @(negedge CLK);
    chk("haz cleared busy1", busy1, 0);
    finish_cycle();

    // Forward picks the youngest of two ALU entries for the same register.
    do_reset();
    drive(1, 8, 32'h11, 1, 10, 32'h100);
    @(negedge CLK); finish_cycle();
    drive(1, 8, 32'h22, 1, 11, 32'h200);
    @(negedge CLK); finish_cycle();
    drive(1, 8, 32'h33, 0, 0, 0);
    @(negedge CLK); finish_cycle();
    drive(0, 0, 0, 0, 0, 0);
    rsel1 = 8; rsel2 = 11;
    @(negedge CLK);
    chk("young busy1", busy1, 1);
    chk("young fwd1_valid", fwd1_valid, FWD);
    chk("young fwd1_dat", fwd1_dat, FWD ? 32'h33 : 32'h0);
    chk("young busy2", busy2, 1);
    chk("young fwd2_valid", fwd2_valid, FWD);
    chk("young fwd2_dat", fwd2_dat, FWD ? 32'h200 : 32'h0);
    finish_cycle();
    idle_cycles(4);
    chk_queues_empty("young");

    // Both buffers match the same register: stall, no forward.
    do_reset();
    drive(1, 9, 32'hAA, 1, 9, 32'hBB);
    @(negedge CLK); finish_cycle();
    drive(0, 0, 0, 0, 0, 0);
    rsel2 = 9;
    @(negedge CLK);
    chk("both busy2", busy2, 1);
    chk("both fwd2_valid", fwd2_valid, 0);
    chk("both fwd2_dat", fwd2_dat, 0);
    finish_cycle();
    idle_cycles(3);
    chk_queues_empty("both");

    // Reset with three entries pending discards them.
    do_reset();
    drive(1, 1, 32'hA1, 1, 17, 32'hB1);
    @(negedge CLK); finish_cycle();
    drive(1, 2, 32'hA2, 1, 18, 32'hB2);
    @(negedge CLK); finish_cycle();
    drive(0, 0, 0, 0, 0, 0);
    rsel1 = 2; rsel2 = 17;
    nRST = 1'b0;
    exp_alu_q.delete(); exp_mem_q.delete();
    #1;
    chk("midrst alu_ready", alu_ready, 0);
    chk("midrst mem_ready", mem_ready, 0);
    chk("midrst rf_WEN", rf_WEN, 0);
    chk("midrst rf_wsel", rf_wsel, 0);
    chk("midrst rf_wdat", rf_wdat, 0);
    chk("midrst busy1", busy1, 0);
    chk("midrst busy2", busy2, 0);
    chk("midrst fwd1_valid", fwd1_valid, 0);
    @(posedge CLK);
    @(negedge CLK) nRST = 1'b1;
    @(posedge CLK); #1;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      chk($sformatf("postrst c%0d rf_WEN", k), rf_WEN, 0);
      chk($sformatf("postrst c%0d busy1", k), busy1, 0);
      finish_cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
